// File: rtl/des_scheduler_if.sv
// Request/status bundle between the button front end and des_scheduler.
// DES_ESTOP_EN adds the emergency-stop input to the bundle.
interface des_scheduler_if #(
    parameter int N_FLOORS = 6,
    parameter int FLOOR_W  = 3
);
    logic [N_FLOORS-1:0]   input_in;
    logic [2*N_FLOORS-3:0] input_out;
`ifdef DES_ESTOP_EN
    logic                  input_estop;
`endif
    logic [FLOOR_W-1:0]    output_now;
    logic                  output_dir;
    logic                  output_door;
    logic                  output_bool;
    logic [FLOOR_W-1:0]    output_des;
    logic [N_FLOORS-1:0]   output_pend_in;
    logic [2*N_FLOORS-3:0] output_pend_out;

`ifdef DES_ESTOP_EN
    modport master (
        output input_in, input_out, input_estop,
        input  output_now, output_dir, output_door, output_bool, output_des,
               output_pend_in, output_pend_out
    );
    modport slave (
        input  input_in, input_out, input_estop,
        output output_now, output_dir, output_door, output_bool, output_des,
               output_pend_in, output_pend_out
    );
`else
    modport master (
        output input_in, input_out,
        input  output_now, output_dir, output_door, output_bool, output_des,
               output_pend_in, output_pend_out
    );
    modport slave (
        input  input_in, input_out,
        output output_now, output_dir, output_door, output_bool, output_des,
               output_pend_in, output_pend_out
    );
`endif
endinterface

// File: rtl/des_scheduler.sv
// LOOK-sweep elevator car scheduler: latches requests, models travel and door timing.
// Optional macro DES_ESTOP_EN adds emergency-stop handling.
module des_scheduler #(
    parameter int N_FLOORS    = 6,
    parameter int FLOOR_W     = 3,
    parameter int MOVE_CYCLES = 16,
    parameter int DOOR_CYCLES = 8
) (
    input  logic           clk,
    input  logic           rst,
    des_scheduler_if.slave sched_io
);
    // state | meaning
    // IDLE  | parked with door closed, waiting for a request
    // MOVE  | travelling, one floor per MOVE_CYCLES clocks
    // DOOR  | door open at output_now for DOOR_CYCLES clocks
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MOVE = 2'd1;
    localparam logic [1:0] ST_DOOR = 2'd2;

    localparam int NH    = 2*N_FLOORS - 2;
    localparam int MAX_C = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int CNT_W = $clog2(MAX_C + 1);
    localparam logic [CNT_W-1:0]   MOVE_LOAD = CNT_W'(MOVE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DOOR_LOAD = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP       = FLOOR_W'(N_FLOORS - 1);

    function automatic logic [N_FLOORS-1:0] up_of(input logic [NH-1:0] h);
        logic [N_FLOORS-1:0] v;
        v = '0;
        for (int f = 0; f < N_FLOORS-1; f++) v[f] = h[2*f];
        return v;
    endfunction

    function automatic logic [N_FLOORS-1:0] dn_of(input logic [NH-1:0] h);
        logic [N_FLOORS-1:0] v;
        v = '0;
        for (int f = 1; f < N_FLOORS; f++) v[f] = h[2*f-1];
        return v;
    endfunction

    function automatic logic [NH-1:0] hall_of(input logic [N_FLOORS-1:0] up,
                                              input logic [N_FLOORS-1:0] dn);
        logic [NH-1:0] h;
        h = '0;
        for (int f = 0; f < N_FLOORS-1; f++) h[2*f]   = up[f];
        for (int f = 1; f < N_FLOORS; f++)   h[2*f-1] = dn[f];
        return h;
    endfunction

    function automatic logic ahead_of(input logic [N_FLOORS-1:0] r,
                                      input logic [FLOOR_W-1:0]  fl,
                                      input logic                d);
        logic a;
        a = 1'b0;
        for (int f = 0; f < N_FLOORS; f++)
            if (r[f] && ((d && f > int'(fl)) || (!d && f < int'(fl)))) a = 1'b1;
        return a;
    endfunction

    logic [1:0]          state_q, state_d;
    logic [FLOOR_W-1:0]  now_q, now_d;
    logic                dir_q, dir_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_FLOORS-1:0] pin_q, pin_d;
    logic [NH-1:0]       pout_q, pout_d;
    logic                estop, halt_q;

    logic [N_FLOORS-1:0] in_g, up_in, dn_in, m_in, m_up, m_dn, m_any, p_any;
    logic [NH-1:0]       out_g;
    logic [FLOOR_W-1:0]  nf, lo, hi, des;
    logic                seen, ahd_nf, ahd_q, ahd_d, stop_here, absorb, d_exit, halt_stop;
    logic [N_FLOORS-1:0] oh_d, clr_in, clr_up, clr_dn;

`ifdef DES_ESTOP_EN
    assign estop = sched_io.input_estop;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) halt_q <= 1'b0;
        else     halt_q <= (state_q == ST_MOVE) && (estop || halt_q) && (state_d == ST_MOVE);
    end
`else
    assign estop  = 1'b0;
    assign halt_q = 1'b0;
`endif

    // Decisions see this edge's presses so a press at the parked floor opens the door at once.
    assign in_g  = estop ? '0 : sched_io.input_in;
    assign out_g = estop ? '0 : sched_io.input_out;
    assign up_in = up_of(out_g);
    assign dn_in = dn_of(out_g);
    assign m_in  = pin_q | in_g;
    assign m_up  = up_of(pout_q | out_g);
    assign m_dn  = dn_of(pout_q | out_g);
    assign m_any = m_in | m_up | m_dn;
    assign p_any = pin_q | up_of(pout_q) | dn_of(pout_q);

    always_comb begin
        lo   = now_q;
        hi   = now_q;
        seen = 1'b0;
        for (int f = 0; f < N_FLOORS; f++) begin
            if (p_any[f]) begin
                if (!seen) lo = FLOOR_W'(f);
                hi   = FLOOR_W'(f);
                seen = 1'b1;
            end
        end
        des = now_q;
        if (dir_q) begin
            if (hi > now_q)      des = hi;
            else if (lo < now_q) des = lo;
        end else begin
            if (lo < now_q)      des = lo;
            else if (hi > now_q) des = hi;
        end
    end

    always_comb begin
        state_d   = state_q;
        now_d     = now_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        halt_stop = 1'b0;
        nf        = dir_q ? now_q + 1'b1 : now_q - 1'b1;
        ahd_nf    = ahead_of(m_any, nf, dir_q);
        stop_here = m_in[nf] | (dir_q ? m_up[nf] : m_dn[nf])
                  | ((dir_q ? m_dn[nf] : m_up[nf]) & ~ahd_nf);
        ahd_q     = ahead_of(m_any, now_q, dir_q);
        absorb    = in_g[now_q] | (up_in[now_q] & (dir_q | ~ahd_q))
                  | (dn_in[now_q] & (~dir_q | ~ahd_q));
        d_exit    = (now_q == TOP) ? 1'b0 : (now_q == '0) ? 1'b1 : dir_q;

        unique case (state_q)
            ST_IDLE: begin
                if (m_any[now_q]) begin
                    state_d = ST_DOOR;
                    cnt_d   = DOOR_LOAD;
                end else if (ahd_q) begin
                    state_d = ST_MOVE;
                    cnt_d   = MOVE_LOAD;
                end else if (ahead_of(m_any, now_q, ~dir_q)) begin
                    state_d = ST_MOVE;
                    dir_d   = ~dir_q;
                    cnt_d   = MOVE_LOAD;
                end
            end
            ST_MOVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (dir_q ? (now_q == TOP) : (now_q == '0)) begin
                    state_d = ST_IDLE;
                end else begin
                    now_d = nf;
                    if (estop || halt_q || stop_here) begin
                        state_d   = ST_DOOR;
                        cnt_d     = DOOR_LOAD;
                        halt_stop = estop || halt_q;
                    end else if (ahd_nf) begin
                        cnt_d = MOVE_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DOOR: begin
                if (!estop) begin
                    if (absorb) begin
                        cnt_d = DOOR_LOAD;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        dir_d   = d_exit;
                        state_d = ST_IDLE;
                        if (ahead_of(m_any, now_q, d_exit)) begin
                            state_d = ST_MOVE;
                            cnt_d   = MOVE_LOAD;
                        end else if (m_any[now_q]) begin
                            // only the opposite hall call is left here: turn round and reopen
                            dir_d   = ~d_exit;
                            state_d = ST_DOOR;
                            cnt_d   = DOOR_LOAD;
                        end else if (ahead_of(m_any, now_q, ~d_exit)) begin
                            dir_d   = ~d_exit;
                            state_d = ST_MOVE;
                            cnt_d   = MOVE_LOAD;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        oh_d   = N_FLOORS'(1) << now_d;
        ahd_d  = ahead_of(m_any, now_d, dir_d);
        clr_in = '0;
        clr_up = '0;
        clr_dn = '0;
        if (state_d == ST_DOOR) begin
            clr_in = oh_d;
            if (dir_d || !ahd_d)  clr_up = oh_d;
            if (!dir_d || !ahd_d) clr_dn = oh_d;
        end
        pin_d  = m_in & ~clr_in;
        pout_d = (pout_q | out_g) & ~hall_of(clr_up, clr_dn);
        if (estop || halt_stop) begin
            pin_d  = '0;
            pout_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            now_q   <= '0;
            dir_q   <= 1'b1;
            cnt_q   <= '0;
            pin_q   <= '0;
            pout_q  <= '0;
        end else begin
            state_q <= state_d;
            now_q   <= now_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            pin_q   <= pin_d;
            pout_q  <= pout_d;
        end
    end

    assign sched_io.output_now      = now_q;
    assign sched_io.output_dir      = dir_q;
    assign sched_io.output_door     = (state_q == ST_DOOR);
    assign sched_io.output_bool     = |p_any;
    assign sched_io.output_des      = des;
    assign sched_io.output_pend_in  = pin_q;
    assign sched_io.output_pend_out = pout_q;
endmodule

// File: tb/tb_des_scheduler.sv
// Directed bench for des_scheduler: expected stop floors are queued when requests are
// driven and popped when the door opens; all other checks are immediate assertions.
module tb_des_scheduler;
    localparam int NF = 6;
    localparam int FW = 3;
    localparam int MC = 4;
    localparam int DC = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   stop_q[$];
    int   n_edges;

    des_scheduler_if #(.N_FLOORS(NF), .FLOOR_W(FW)) sif ();

    des_scheduler #(
        .N_FLOORS(NF), .FLOOR_W(FW), .MOVE_CYCLES(MC), .DOOR_CYCLES(DC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sched_io (sif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_now"},      sif.output_now, 0);
        check({tag, "_dir"},      sif.output_dir, 1);
        check({tag, "_door"},     sif.output_door, 0);
        check({tag, "_bool"},     sif.output_bool, 0);
        check({tag, "_des"},      sif.output_des, 0);
        check({tag, "_pend_in"},  sif.output_pend_in, 0);
        check({tag, "_pend_out"}, sif.output_pend_out, 0);
    endtask

    task automatic pulse_reset();
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic press(input logic [NF-1:0] cab, input logic [2*NF-3:0] hall);
        sif.input_in  = cab;
        sif.input_out = hall;
        tick();
        sif.input_in  = '0;
        sif.input_out = '0;
    endtask

    task automatic wait_now(input string tag, input int target, input int budget, output int edges);
        edges = 0;
        while (int'(sif.output_now) != target && edges < budget) begin
            tick();
            edges++;
        end
        check(tag, sif.output_now, target);
    endtask

    task automatic wait_stop(input string tag, input int budget);
        logic prev;
        bit   got;
        int   exp_f;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            prev = sif.output_door;
            tick();
            if (sif.output_door === 1'b1 && prev === 1'b0) got = 1'b1;
        end
        exp_f = (stop_q.size() > 0) ? stop_q.pop_front() : -1;
        check({tag, "_arrived"}, got, 1);
        check({tag, "_floor"}, sif.output_now, exp_f);
    endtask

    task automatic wait_door_low(input string tag, input int budget);
        int n;
        n = 0;
        while (sif.output_door !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, sif.output_door, 0);
    endtask

    initial begin
        int door_cnt;
        rst           = 1'b1;
        sif.input_in  = '0;
        sif.input_out = '0;
`ifdef DES_ESTOP_EN
        sif.input_estop = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("rst0");

        // single cab call 0 -> 4: latency, door length, clearing
        press(6'b010000, '0);
        check("t2_bool", sif.output_bool, 1);
        check("t2_des", sif.output_des, 4);
        check("t2_pend_in", sif.output_pend_in, 6'b010000);
        wait_now("t2_now4", 4, 40, n_edges);
        check("t2_latency", n_edges + 1, 1 + 4*MC);
        check("t2_door_open", sif.output_door, 1);
        check("t2_pend_clr", sif.output_pend_in, 0);
        door_cnt = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (sif.output_door !== 1'b1) break;
            door_cnt++;
        end
        check("t2_door_cycles", door_cnt, DC);
        check("t2_bool_idle", sif.output_bool, 0);
        check("t2_now_idle", sif.output_now, 4);

        // async reset while travelling down past floor 2
        press(6'b000001, '0);
        check("t1_dir_flip", sif.output_dir, 0);
        wait_now("t1_now2", 2, 30, n_edges);
        tick();
        check("t1_mid_move", sif.output_door, 0);
        #2 rst = 1'b1;
        #1 check_reset_outputs("t1_async");
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("t1_after");

        // park at floor 1 going up, then LOOK sweep with down hall calls at 2 and 3
        stop_q.push_back(1);
        press(6'b000010, '0);
        wait_stop("t3_setup", 20);
        wait_door_low("t3_setup_close", 10);
        check("t3_setup_dir", sif.output_dir, 1);
        press(6'b010000, 10'b0000101000);
        check("t3_des", sif.output_des, 4);
        check("t3_pend_out", sif.output_pend_out, 10'b0000101000);
        stop_q.push_back(4);
        stop_q.push_back(3);
        stop_q.push_back(2);
        wait_stop("t3_s4", 40);
        check("t3_s4_dir", sif.output_dir, 1);
        check("t3_downs_kept", sif.output_pend_out, 10'b0000101000);
        wait_stop("t3_s3", 40);
        check("t3_s3_dir", sif.output_dir, 0);
        check("t3_s3_pend", sif.output_pend_out, 10'b0000001000);
        wait_stop("t3_s2", 40);
        check("t3_s2_pend", sif.output_pend_out, 0);
        wait_door_low("t3_close", 10);
        check("t3_bool", sif.output_bool, 0);

        // cab call at the parked floor opens the door on the sampling edge
        stop_q.push_back(3);
        press(6'b001000, '0);
        wait_stop("t4_setup", 20);
        wait_door_low("t4_setup_close", 10);
        press(6'b001000, '0);
        check("t4_door", sif.output_door, 1);
        check("t4_now", sif.output_now, 3);
        check("t4_pend_in", sif.output_pend_in, 0);
        tick();
        check("t4_pend_in2", sif.output_pend_in, 0);
        wait_door_low("t4_close", 10);

        // top-floor down call from floor 0
        pulse_reset();
        stop_q.push_back(5);
        press('0, 10'b1000000000);
        check("t5_des", sif.output_des, 5);
        wait_stop("t5_s5", 40);
        check("t5_call_clr", sif.output_pend_out, 0);
        wait_door_low("t5_close", 10);
        check("t5_dir", sif.output_dir, 0);
        check("t5_bool", sif.output_bool, 0);

`ifdef DES_ESTOP_EN
        // estop midway between floors 1 and 2 on a 0 -> 3 trip
        pulse_reset();
        press(6'b001000, '0);
        wait_now("t6_now1", 1, 20, n_edges);
        tick();
        sif.input_estop = 1'b1;
        stop_q.push_back(2);
        wait_stop("t6_s2", 20);
        check("t6_pend_in", sif.output_pend_in, 0);
        check("t6_bool", sif.output_bool, 0);
        sif.input_in = 6'b100000;
        tick(6);
        sif.input_in = '0;
        check("t6_held", sif.output_door, 1);
        check("t6_ignored", sif.output_pend_in, 0);
        sif.input_estop = 1'b0;
        wait_door_low("t6_release", 10);
        check("t6_now", sif.output_now, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
